// File: rtl/layer_output_serializer_pkg.sv
// Shared types and defaults for the layer output serializer.
// It also provides a helper that sizes the word index.
package layer_output_serializer_pkg;

  localparam int DEFAULT_NUM_NEURONS = 10;
  localparam int DEFAULT_DATA_WIDTH  = 16;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  // A single-neuron layer still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_output_serializer_if.sv
// Parallel activation bus in, serialized word stream out.
// Also carries the busy and overflow status flags.
interface layer_output_serializer_if
  import layer_output_serializer_pkg::*;
#(
  parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) ();

  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
  logic [NUM_NEURONS-1:0]            in_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic                              out_last;
  logic                              busy;
  logic                              overflow;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_last, busy, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_last, busy, overflow
  );

endinterface

// File: rtl/layer_output_serializer_lane_capture_bank.sv
// Per-lane capture registers and an arrival mask for one frame.
// frame_data merges this cycle's accepted lanes so that a frame can be loaded at its completing edge.
module lane_capture_bank #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  input  logic                              accept,
  output logic [NUM_NEURONS-1:0]            mask,
  output logic                              frame_done,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] frame_data
);

  logic [DATA_WIDTH-1:0]  lane_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] take;

  assign take       = accept ? in_valid : '0;
  assign frame_done = &(mask | take);

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_view
    assign frame_data[i*DATA_WIDTH +: DATA_WIDTH] =
      take[i] ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : lane_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) lane_q[i] <= '0;
    end else begin
      mask <= frame_done ? '0 : (mask | take);
      for (int i = 0; i < NUM_NEURONS; i++)
        if (take[i]) lane_q[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/layer_output_serializer.sv
// Collects one activation per neuron into a frame and streams the frame out, lane 0 first.
// A completed frame waits in the capture bank while the previous frame drains from the shift buffer.
//   state     | meaning
//   SER_IDLE  | shift buffer empty, out_valid low
//   SER_SHIFT | presenting shift buffer word [index]
module layer_output_serializer
  import layer_output_serializer_pkg::*;
#(
  parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  layer_output_serializer_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  ser_state_t                        state_q, state_d;
  logic [IDX_W-1:0]                  index_q;
  logic                              pend_q;
  logic                              overflow_q;
  logic [DATA_WIDTH-1:0]             shift_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]            mask;
  logic                              frame_done;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] frame_data;
  logic                              hs, last_hs, out_free, load_new, load_pend, load;

  lane_capture_bank #(
    .NUM_NEURONS(NUM_NEURONS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .accept    (!pend_q),
    .mask      (mask),
    .frame_done(frame_done),
    .frame_data(frame_data)
  );

  assign hs        = (state_q == SER_SHIFT) && bus.out_ready;
  assign last_hs   = hs && (index_q == LAST_IDX);
  assign out_free  = (state_q == SER_IDLE) || last_hs;
  assign load_new  = frame_done && out_free;
  // With pend set the bank accepts nothing, so frame_data is exactly the held frame.
  assign load_pend = pend_q && last_hs;
  assign load      = load_new || load_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SER_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE:  if (load) state_d = SER_SHIFT;
      SER_SHIFT: if (last_hs && !load) state_d = SER_IDLE;
      default:   state_d = SER_IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (state_q == SER_SHIFT);
    bus.out_data  = bus.out_valid ? shift_q[index_q] : '0;
    bus.out_last  = bus.out_valid && (index_q == LAST_IDX);
    bus.busy      = (state_q == SER_SHIFT) || pend_q || (mask != '0);
    bus.overflow  = overflow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q    <= '0;
      pend_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) shift_q[i] <= '0;
    end else begin
      if (load) begin
        index_q <= '0;
        for (int i = 0; i < NUM_NEURONS; i++)
          shift_q[i] <= frame_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (hs) begin
        index_q <= index_q + 1'b1;
      end

      if (load_pend)                   pend_q <= 1'b0;
      else if (frame_done && !out_free) pend_q <= 1'b1;

      // Dropped input while a frame is pending, or a lane repeated before its frame completed.
      if ((pend_q && (bus.in_valid != '0)) || ((bus.in_valid & mask) != '0))
        overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed scenarios plus randomized traffic, checked against a queue-based frame model.
module tb_layer_output_serializer;

  localparam int N  = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_output_serializer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) bus ();

  layer_output_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as word queues.
  logic [DW-1:0] m_lane [N];
  logic [DW-1:0] m_pf   [N];
  logic [N-1:0]  m_mask;
  logic [DW-1:0] m_sq   [$];
  bit            m_pend;
  bit            m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mask = '0;
      m_sq.delete();
      m_pend = 0;
      m_ovf  = 0;
      for (int i = 0; i < N; i++) begin m_lane[i] = '0; m_pf[i] = '0; end
    end else begin
      bit pend_old;
      pend_old = m_pend;
      if (m_sq.size() > 0 && bus.out_ready) void'(m_sq.pop_front());
      if (pend_old && m_sq.size() == 0) begin
        for (int i = 0; i < N; i++) m_sq.push_back(m_pf[i]);
        m_pend = 0;
      end
      if (bus.in_valid != '0) begin
        if (pend_old) m_ovf = 1;
        else begin
          for (int i = 0; i < N; i++)
            if (bus.in_valid[i]) begin
              if (m_mask[i]) m_ovf = 1;
              m_lane[i] = bus.in_data[i*DW +: DW];
              m_mask[i] = 1'b1;
            end
          if (&m_mask) begin
            m_mask = '0;
            if (m_sq.size() == 0) for (int i = 0; i < N; i++) m_sq.push_back(m_lane[i]);
            else begin
              m_pend = 1;
              for (int i = 0; i < N; i++) m_pf[i] = m_lane[i];
            end
          end
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  logic [DW-1:0] got_data [$];
  int            got_cyc  [$];

  always @(negedge clk) begin
    bit mv;
    mv = (m_sq.size() > 0);
    chk("valid", 32'(bus.out_valid), 32'(mv));
    if (mv) begin
      chk("data", 32'(bus.out_data), 32'(m_sq[0]));
      chk("last", 32'(bus.out_last), 32'(m_sq.size() == 1));
    end
    chk("busy", 32'(bus.busy), 32'(mv || m_pend || (m_mask != '0)));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (bus.out_valid && bus.out_ready) begin
      got_data.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [DW-1:0] base);
    bus.in_valid = v;
    for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = base + DW'(i);
  endtask

  task automatic frame(input logic [DW-1:0] base);
    drive('1, base);
    tick();
    bus.in_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_words(input string name, input int start, input int n,
                             input logic [DW-1:0] base, input bit contig);
    for (int k = 0; k < n; k++) begin
      chk({name, " word"}, 32'(got_data[start+k]), 32'(base + DW'(k)));
      if (contig && k > 0) chk({name, " gap"}, 32'(got_cyc[start+k] - got_cyc[start+k-1]), 32'd1);
    end
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    do_reset();
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", 32'(bus.out_data), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);

    // Aligned frame
    got_data.delete(); got_cyc.delete();
    chk("t1 pre valid", 32'(bus.out_valid), 32'd0);
    frame(16'h0001);
    chk("t1 latency valid", 32'(bus.out_valid), 32'd1);
    chk("t1 first data", 32'(bus.out_data), 32'h0001);
    repeat (12) tick();
    chk("t1 count", 32'(got_data.size()), 32'd10);
    check_words("t1", 0, 10, 16'h0001, 1);

    // Skewed arrival
    got_data.delete(); got_cyc.delete();
    drive(N'(1) << (N-1), 16'h0001);
    tick();
    bus.in_valid = '0;
    repeat (2) begin
      chk("t2 early valid", 32'(bus.out_valid), 32'd0);
      tick();
    end
    drive({1'b0, {(N-1){1'b1}}}, 16'h0001);
    chk("t2 early valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = '0;
    chk("t2 valid", 32'(bus.out_valid), 32'd1);
    repeat (12) tick();
    check_words("t2", 0, 10, 16'h0001, 1);
    chk("t2 overflow", 32'(bus.overflow), 32'd0);

    // Back-to-back frames, second completes while first is at index 4
    got_data.delete(); got_cyc.delete();
    frame(16'h0001);
    repeat (3) tick();
    frame(16'h0100);
    chk("t3 busy", 32'(bus.busy), 32'd1);
    repeat (22) tick();
    chk("t3 count", 32'(got_data.size()), 32'd20);
    check_words("t3a", 0, 10, 16'h0001, 1);
    check_words("t3b", 10, 10, 16'h0100, 1);
    chk("t3 seam", 32'(got_cyc[10] - got_cyc[9]), 32'd1);

    // Backpressure at index 2
    got_data.delete(); got_cyc.delete();
    frame(16'h0001);
    repeat (2) tick();
    bus.out_ready = 1'b0;
    repeat (3) begin
      #3;
      chk("t4 hold data", 32'(bus.out_data), 32'h0003);
      @(posedge clk); #2;
    end
    bus.out_ready = 1'b1;
    repeat (12) tick();
    chk("t4 count", 32'(got_data.size()), 32'd10);
    check_words("t4", 0, 10, 16'h0001, 0);

    // Overflow while a frame is pending
    got_data.delete(); got_cyc.delete();
    frame(16'h0001);
    frame(16'h0100);
    bus.in_valid = N'(1);
    bus.in_data[DW-1:0] = 16'hBEEF;
    tick();
    bus.in_valid = '0;
    chk("t5 overflow", 32'(bus.overflow), 32'd1);
    repeat (22) tick();
    chk("t5 count", 32'(got_data.size()), 32'd20);
    check_words("t5a", 0, 10, 16'h0001, 1);
    check_words("t5b", 10, 10, 16'h0100, 1);
    chk("t5 sticky", 32'(bus.overflow), 32'd1);

    // Async reset mid-shift with a pending frame
    do_reset();
    frame(16'h0001);
    frame(16'h0100);
    repeat (4) tick();
    #1 rst = 1'b1;
    #1;
    chk("t6 rst valid", 32'(bus.out_valid), 32'd0);
    chk("t6 rst last", 32'(bus.out_last), 32'd0);
    chk("t6 rst data", 32'(bus.out_data), 32'd0);
    chk("t6 rst busy", 32'(bus.busy), 32'd0);
    chk("t6 rst overflow", 32'(bus.overflow), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    got_data.delete(); got_cyc.delete();
    frame(16'h0200);
    repeat (14) tick();
    chk("t6 count", 32'(got_data.size()), 32'd10);
    check_words("t6", 0, 10, 16'h0200, 1);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.in_valid[i] = ($urandom_range(0, 5) == 0);
        bus.in_data[i*DW +: DW] = DW'($urandom);
      end
      bus.out_ready = (c > 1500) ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
    end
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    repeat (30) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
